uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQ, 4, number of requesters (legal 2..8)
- DATA_WIDTH, 8, byte width per request
- TIMEOUT_CYCLES, 16, watchdog limit in WAIT_BUSY (legal >=2)
REQ-002 Ports SHALL be, one per line:
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous active-high reset
- i_req_valid  in  NUM_REQ  request k valid, bit k
- i_req_data  in  NUM_REQ*DATA_WIDTH  requester k byte at [k*DATA_WIDTH +: DATA_WIDTH]
- o_req_ready  out  NUM_REQ  one-hot accept pulse to requester k
- o_grant  out  NUM_REQ  one-hot owner of current transfer, 0 when idle
- o_tx_start  out  1  one-cycle start pulse to transmitter
- o_tx_data  out  DATA_WIDTH  byte to transmitter
- i_tx_busy  in  1  transmitter busy flag
- o_busy  out  1  high in any state except IDLE
- o_timeout  out  1  one-cycle watchdog pulse
REQ-003 One clock; reset asynchronous and active-high.

Function
REQ-004 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-005 IDLE: when any i_req_valid bit is set and i_tx_busy=0, winner SHALL be the first set bit searching from pointer p upward, modulo NUM_REQ; i_req_data of winner latched into o_tx_data; o_grant set one-hot; next state ISSUE.
REQ-006 IDLE with i_tx_busy=1 SHALL remain in IDLE, no grant, regardless of requests.
REQ-007 ISSUE SHALL last exactly one cycle with o_tx_start=1 and o_req_ready[winner]=1; next state WAIT_BUSY.
REQ-008 Latency: request valid with transmitter idle in cycle N SHALL yield o_tx_start and o_req_ready in cycle N+1.
REQ-009 WAIT_BUSY SHALL advance to WAIT_DONE on first cycle i_tx_busy=1.
REQ-010 WAIT_DONE SHALL return to IDLE on first cycle i_tx_busy=0; on that transition p SHALL become (winner+1) mod NUM_REQ and o_grant SHALL clear.
REQ-011 o_tx_data and o_grant SHALL hold constant from ISSUE through WAIT_DONE.
REQ-012 Requesters SHALL hold valid and data stable until ready; valid withdrawn before arbitration SHALL simply not be considered.
REQ-013 i_req_valid changes outside IDLE SHALL be ignored; no o_req_ready outside ISSUE.
REQ-014 At most one o_req_ready bit and one o_grant bit SHALL ever be set.
REQ-015 Pointer wrap: winner NUM_REQ-1 SHALL set p=0.

Reset
REQ-016 Reset SHALL force state IDLE, p=0, and o_req_ready, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout all 0.
REQ-017 Reset mid-transfer SHALL abort without a further o_tx_start or o_req_ready; the aborted requester is not acknowledged again.
REQ-018 First grant after reset release SHALL occur no earlier than the second rising edge after deassertion.

Configuration
REQ-019 Macro UART_TX_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT_BUSY; after TIMEOUT_CYCLES cycles without i_tx_busy=1, o_timeout pulses one cycle, o_grant clears, p advances as in REQ-010, state returns IDLE.
REQ-020 Macro undefined: no counter; WAIT_BUSY waits indefinitely; o_timeout tied 0.

Verification
REQ-021 Single request: valid=4'b0100, data[23:16]=8'hA5, tx idle -> next cycle o_tx_start=1, o_req_ready=4'b0100, o_tx_data=8'hA5, o_grant=4'b0100.
REQ-022 Fairness: valid=4'b1111 held, transmitter model busy 10 cycles each -> grants in order 0,1,2,3,0; each exactly one ready pulse.
REQ-023 Wrap/skip: p=3 after grant to 2, valid=4'b0011 -> grant 0, then p=1, next grant 1.
REQ-024 Busy block: i_tx_busy=1 in IDLE with valid=4'b0001 for 5 cycles -> no o_tx_start; start one cycle after busy drops.
REQ-025 Reset mid-transfer: assert i_reset in WAIT_DONE -> all outputs 0 immediately, no start after release until a new request.
REQ-026 Timeout (macro defined, TIMEOUT_CYCLES=16): i_tx_busy stuck 0 after start -> o_timeout pulse 16 cycles after entering WAIT_BUSY, return IDLE, p advanced; macro undefined -> o_busy stays 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester byte at a time to a UART transmitter.
// Optional watchdog in WAIT_BUSY enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic                            o_tx_start,
  output logic [DATA_WIDTH-1:0]           o_tx_data,
  input  logic                            i_tx_busy,
  output logic                            o_busy,
  output logic                            o_timeout
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        win_q, win_d;
  logic [PTR_W-1:0]        pick_c, next_ptr_c;
  logic [SUM_W-1:0]        sum_c;
  logic                    found_c;
  logic                    arm_q, arm_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    sum_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum_c = SUM_W'(ptr_q) + SUM_W'(i);
      if (sum_c >= SUM_W'(NUM_REQ)) begin
        sum_c = sum_c - SUM_W'(NUM_REQ);
      end
      if (!found_c && i_req_valid[PTR_W'(sum_c)]) begin
        found_c = 1'b1;
        pick_c  = PTR_W'(sum_c);
      end
    end
  end

  assign next_ptr_c = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    arm_d     = 1'b1;
    ready_d   = '0;
    grant_d   = grant_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    data_d    = data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // arm_q delays the first grant to the second edge after reset release
        if (arm_q && found_c && !i_tx_busy) begin
          win_d           = pick_c;
          grant_d         = '0;
          grant_d[pick_c] = 1'b1;
          ready_d         = '0;
          ready_d[pick_c] = 1'b1;
          start_d         = 1'b1;
          data_d          = DATA_WIDTH'(i_req_data >> (32'(pick_c) * DATA_WIDTH));
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          ptr_d     = next_ptr_c;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          grant_d = '0;
          ptr_d   = next_ptr_c;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      arm_q     <= 1'b0;
      ready_q   <= '0;
      grant_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      arm_q     <= arm_d;
      ready_q   <= ready_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign o_req_ready = ready_q;
  assign o_grant     = grant_q;
  assign o_tx_start  = start_q;
  assign o_tx_data   = data_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requests, expected grants queued,
// a negedge monitor pops and compares on every transmitter start pulse.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic [3:0]  o_req_ready;
  logic [3:0]  o_grant;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_timeout;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] oh;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [3:0] cur_grant = '0;
  logic [7:0] cur_data = '0;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .o_req_ready(o_req_ready),
    .o_grant    (o_grant),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (tx_busy),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] oh, input logic [7:0] d);
    exp_t e;
    e.oh   = oh;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ready"},   32'(o_req_ready), 32'd0);
    chk({name, "_grant"},   32'(o_grant),     32'd0);
    chk({name, "_start"},   32'(o_tx_start),  32'd0);
    chk({name, "_data"},    32'(o_tx_data),   32'd0);
    chk({name, "_busy"},    32'(o_busy),      32'd0);
    chk({name, "_timeout"}, 32'(o_timeout),   32'd0);
  endtask

  // Requesters drop valid on ready (unless held); transmitter stays busy busy_len cycles per start.
  task automatic drain(input int busy_len, input int budget, input bit hold,
                       input int max_starts, output int first_start);
    int tx_cnt;
    int starts;
    bit done;
    tx_cnt = 0;
    starts = 0;
    done = 1'b0;
    first_start = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (o_tx_start) begin
        if (first_start < 0) first_start = c;
        starts++;
        tx_cnt = busy_len;
        if (!hold) req_valid = req_valid & ~o_req_ready;
        if (max_starts != 0 && starts >= max_starts) req_valid = '0;
      end
      tx_busy = (tx_cnt != 0);
      if (tx_cnt != 0) tx_cnt--;
      if (req_valid == 4'b0 && !o_busy && !tx_busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: valid=%b busy=%b expected idle within %0d cycles",
               req_valid, o_busy, budget);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each start pulse, hold check otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_vs_grant", 32'(o_req_ready), 32'(o_tx_start ? o_grant : 4'b0));
      chk("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
      if (o_tx_start) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: grant=%b data=%h expected no start", o_grant, o_tx_data);
        end else begin
          mon_e = sb_q.pop_front();
          chk("start_ready", 32'(o_req_ready), 32'(mon_e.oh));
          chk("start_grant", 32'(o_grant),     32'(mon_e.oh));
          chk("start_data",  32'(o_tx_data),   32'(mon_e.data));
        end
        cur_grant = o_grant;
        cur_data  = o_tx_data;
      end else if (o_grant != 4'b0) begin
        chk("hold_grant", 32'(o_grant),   32'(cur_grant));
        chk("hold_data",  32'(o_tx_data), 32'(cur_data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "bench time limit");
  end

  initial begin
    int fs;
    int starts;

    // Reset state, then first grant exactly two edges after release
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    repeat (2) @(negedge clk);
    check_zero("reset");
    push_exp(4'b0001, 8'h3C);
    @(posedge clk);
    #1 rst = 1'b0;
    drain(3, 50, 1'b0, 0, fs);
    chk("first_grant_latency", 32'(fs), 32'd2);

    // Single request, one-cycle latency
    req_data  = 32'h11A5_2233;
    req_valid = 4'b0100;
    push_exp(4'b0100, 8'hA5);
    drain(3, 50, 1'b0, 0, fs);
    chk("single_req_latency", 32'(fs), 32'd0);

    // p=3: valid 0011 skips to 0, then 1
    req_data  = 32'h0000_C35A;
    req_valid = 4'b0011;
    push_exp(4'b0001, 8'h5A);
    push_exp(4'b0010, 8'hC3);
    drain(3, 80, 1'b0, 0, fs);

    // Busy transmitter blocks arbitration in IDLE
    req_data  = 32'h0000_00E7;
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_block_start", 32'(o_tx_start), 32'd0);
      chk("busy_block_grant", 32'(o_grant),    32'd0);
    end
    push_exp(4'b0001, 8'hE7);
    tx_busy = 1'b0;
    drain(3, 50, 1'b0, 0, fs);
    chk("busy_release_latency", 32'(fs), 32'd0);

    // Reset during WAIT_DONE aborts the transfer
    req_data  = 32'h0000_4400;
    req_valid = 4'b0010;
    push_exp(4'b0010, 8'h44);
    fs = -1;
    for (int c = 0; c < 10 && fs < 0; c++) begin
      @(negedge clk);
      if (o_tx_start) begin
        fs = c;
        req_valid = '0;
        tx_busy = 1'b1;
      end
    end
    chk("abort_start_seen", 32'(fs), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_in_transfer", 32'(o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_zero("reset_mid_transfer");
    tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    starts = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_tx_start) starts++;
    end
    chk("no_start_after_abort", 32'(starts), 32'd0);
    req_data  = 32'h7E00_0000;
    req_valid = 4'b1000;
    push_exp(4'b1000, 8'h7E);
    drain(3, 50, 1'b0, 0, fs);
    chk("post_reset_latency", 32'(fs), 32'd0);

    // Fairness: all four held valid, grants 0,1,2,3,0
    req_data  = 32'h4433_2211;
    req_valid = 4'b1111;
    push_exp(4'b0001, 8'h11);
    push_exp(4'b0010, 8'h22);
    push_exp(4'b0100, 8'h33);
    push_exp(4'b1000, 8'h44);
    push_exp(4'b0001, 8'h11);
    drain(10, 300, 1'b1, 5, fs);

    // Transmitter never raises busy after start
    req_data  = 32'h0000_0099;
    req_valid = 4'b0001;
    push_exp(4'b0001, 8'h99);
    fs = -1;
    for (int c = 0; c < 10 && fs < 0; c++) begin
      @(negedge clk);
      if (o_tx_start) begin
        fs = c;
        req_valid = '0;
      end
    end
    chk("stuck_start_seen", 32'(fs), 32'd0);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
`ifdef UART_TX_ARB_TIMEOUT_EN
      chk("timeout_pulse", 32'(o_timeout), 32'(j == 17));
      if (j < 17) begin
        chk("timeout_wait_busy", 32'(o_busy), 32'd1);
      end else if (j == 17) begin
        chk("timeout_idle_busy",  32'(o_busy),  32'd0);
        chk("timeout_idle_grant", 32'(o_grant), 32'd0);
      end
`else
      chk("no_timeout", 32'(o_timeout), 32'd0);
      chk("stuck_busy", 32'(o_busy),    32'd1);
`endif
    end
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("back_to_idle", 32'(o_busy), 32'd0);

    // Pointer advanced past 0: valid 0011 grants 1 first, then 0
    req_data  = 32'h0000_6612;
    req_valid = 4'b0011;
    push_exp(4'b0010, 8'h66);
    push_exp(4'b0001, 8'h12);
    drain(3, 80, 1'b0, 0, fs);
    chk("post_stuck_latency", 32'(fs), 32'd0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
